fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register that feeds the decode/control stage. Holds the program counter, reads a combinational instruction memory, and registers the fetched word and its PC for decode. It also handles hazard stalls, branch/jump redirects and an ecall halt. Decode consumes `ifInstr` as its instruction input, and this stage's `stall` input is the same hazard stall that decode receives.

## Interface
- `RESET_PC`, 32'h00000000: PC value loaded on reset.
- `NOP_INSTR`, 32'h00000013: bubble word (addi x0,x0,0) written into IF/ID on flush and halt.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hazard stall from the hazard unit; freezes PC and IF/ID.
- `redirect` in 1: a taken branch or jal resolved downstream.
- `redirectPc` in 32: target address for `redirect`; bits [1:0] are ignored and forced to 0.
- `imemData` in 32: instruction word at `imemAddr`, valid in the same cycle.
- `imemAddr` out 32: current PC, driven combinationally from the PC register.
- `ifInstr` out 32: IF/ID instruction register.
- `ifPc` out 32: IF/ID PC register (address of `ifInstr`).
- `ifValid` out 1: high when `ifInstr` is a real fetched instruction; low for a bubble.
- `halted` out 1: high while in the HALT state.
- `fetchCount` out 32: count of accepted fetches, saturating.

## Operation
- Two states: RUN and HALT. Reset enters RUN.
- Reset values: PC=`RESET_PC`, `ifInstr`=`NOP_INSTR`, `ifPc`=0, `ifValid`=0, `halted`=0, `fetchCount`=0.
- Per-cycle priority: `rst` > `redirect` > `stall` > state action.
- Redirect, in any state and regardless of `stall`:
  - PC <= {redirectPc[31:2],2'b00}.
  - `ifInstr` <= `NOP_INSTR`, `ifValid` <= 0.
  - state <= RUN.
  - `fetchCount` is unchanged.
- Stall without redirect:
  - PC, `ifInstr`, `ifPc`, `ifValid`, state and `fetchCount` all hold.
- RUN, no stall, no redirect (accepted fetch):
  - `ifInstr` <= `imemData`, `ifPc` <= PC, `ifValid` <= 1, PC <= PC+4.
  - `fetchCount` <= `fetchCount`+1, saturating at 32'hFFFFFFFF.
  - If `imemData[6:0]` == 7'b1110011 (ecall), state <= HALT. The ecall is still latched into IF/ID so decode sees it.
- HALT, no stall, no redirect:
  - PC holds at ecall address+4.
  - `ifInstr` <= `NOP_INSTR`, `ifValid` <= 0.
  - No count increment.
- HALT is left only by `rst` or `redirect`. A redirect means the ecall was on a wrong path (squashed by an older taken branch).
- PC arithmetic is modulo 2^32: PC=32'hFFFFFFFC wraps to 0.
- `imemAddr` bits [1:0] are always 0.

## Timing
- Fetch latency is 1 cycle: the word at PC in cycle N appears on `ifInstr` in cycle N+1.
- Redirect penalty:
  - The redirect cycle loads the target PC and writes a bubble.
  - The target instruction appears on `ifInstr` 2 cycles after `redirect` is sampled.
- Stall: outputs in cycle N+1 equal outputs in cycle N. `imemAddr` is constant across the stall.
- `halted` rises in the cycle after the ecall is fetched, the same cycle the ecall appears on `ifInstr`.
- Reset mid-operation: all registers take their reset values on the next edge. No partial state survives.
- Redirect and stall in the same cycle: redirect wins and the bubble is written.
- Redirect in the same cycle an ecall is on `imemData`: the ecall is discarded and the state stays RUN.

## Test plan
- Sequential fetch: reset, memory holds 0x00000093, 0x00100113, ... → `ifPc` is 0, 4, 8 on consecutive cycles, `ifValid`=1 from the 2nd edge, and `fetchCount` = 3 after 3 fetches.
- Stall: assert `stall` for 2 cycles at PC=8 → `ifInstr` and `ifPc` (=4) hold, and `imemAddr` stays 8. On release, fetch resumes at 8.
- Redirect: `redirect`=1 with `redirectPc`=0x42 while `stall`=1 → next cycle `imemAddr`=0x40, `ifInstr`=0x00000013, `ifValid`=0. The following cycle `ifPc`=0x40.
- Ecall halt: 0x00000073 at address 0x10 → `ifInstr`=0x73, `ifPc`=0x10, `halted`=1, `imemAddr` stays 0x14. Afterwards `ifValid`=0 indefinitely and `fetchCount` is frozen.
- Halt escape and wrap:
  - `redirect` to 0xFFFFFFFC while halted → `halted`=0, the next fetch is at 0xFFFFFFFC, then 0x00000000.
  - `fetchCount` preloaded near max saturates at 0xFFFFFFFF.
- Mid-run reset: assert `rst` for 1 cycle during a redirect → PC=`RESET_PC`, all outputs return to their reset values, and the redirect is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: PC, stall/redirect
// handling, ecall halt and a saturating count of accepted fetches.
module fetch_stage #(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR         = 32'h0000_0013,
  parameter logic [31:0] FETCH_COUNT_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  input  logic [31:0] imemData,
  output logic [31:0] imemAddr,
  output logic [31:0] ifInstr,
  output logic [31:0] ifPc,
  output logic        ifValid,
  output logic        halted,
  output logic [31:0] fetchCount
);

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] if_pc_q;
  logic        valid_q;
  logic [31:0] count_q;
  logic [31:0] count_d;

  assign count_d = (count_q == '1) ? count_q : count_q + 32'd1;

  // Priority: reset, then redirect (squashes and leaves HALT), then stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      if_pc_q <= '0;
      valid_q <= 1'b0;
      count_q <= FETCH_COUNT_RESET;
    end else if (redirect) begin
      state_q <= RUN;
      pc_q    <= {redirectPc[31:2], 2'b00};
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        RUN: begin
          instr_q <= imemData;
          if_pc_q <= pc_q;
          valid_q <= 1'b1;
          pc_q    <= pc_q + 32'd4;
          count_q <= count_d;
          if (imemData[6:0] == OPC_SYSTEM) state_q <= HALT;
        end
        HALT: begin
          instr_q <= NOP_INSTR;
          valid_q <= 1'b0;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign imemAddr   = pc_q;
  assign ifInstr    = instr_q;
  assign ifPc       = if_pc_q;
  assign ifValid    = valid_q;
  assign halted     = (state_q == HALT);
  assign fetchCount = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/redirect/reset
// traffic, all checked cycle by cycle against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] SAT_START = 32'hFFFF_FFFA;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirectPc, imemData, imemAddr, ifInstr, ifPc, fetchCount;
  logic        ifValid, halted;

  logic [31:0] imemData2, imemAddr2, ifInstr2, ifPc2, fetchCount2;
  logic        ifValid2, halted2;

  logic [31:0] mem [256];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model state
  logic [31:0] m_pc, m_instr, m_ifpc, m_cnt, m_cnt2;
  logic        m_valid, m_halt;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirectPc(redirectPc), .imemData(imemData), .imemAddr(imemAddr),
    .ifInstr(ifInstr), .ifPc(ifPc), .ifValid(ifValid), .halted(halted),
    .fetchCount(fetchCount)
  );

  fetch_stage #(.FETCH_COUNT_RESET(SAT_START)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirectPc(redirectPc), .imemData(imemData2), .imemAddr(imemAddr2),
    .ifInstr(ifInstr2), .ifPc(ifPc2), .ifValid(ifValid2), .halted(halted2),
    .fetchCount(fetchCount2)
  );

  always #5 clk = ~clk;

  assign imemData  = mem[imemAddr[9:2]];
  assign imemData2 = mem[imemAddr2[9:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  task automatic model_update(input bit r, input bit s, input bit d, input logic [31:0] t);
    logic [31:0] word;
    word = mem[m_pc[9:2]];
    if (r) begin
      m_pc = 0; m_instr = NOP; m_ifpc = 0; m_valid = 0; m_halt = 0;
      m_cnt = 0; m_cnt2 = SAT_START;
    end else if (d) begin
      m_pc = t & ~32'd3; m_instr = NOP; m_valid = 0; m_halt = 0;
    end else if (s) begin
      // everything holds
    end else if (!m_halt) begin
      m_instr = word; m_ifpc = m_pc; m_valid = 1; m_pc = m_pc + 4;
      m_cnt = sat_inc(m_cnt); m_cnt2 = sat_inc(m_cnt2);
      if (word[6:0] == 7'h73) m_halt = 1;
    end else begin
      m_instr = NOP; m_valid = 0;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit d, input logic [31:0] t);
    rst = r; stall = s; redirect = d; redirectPc = t;
    @(posedge clk);
    model_update(r, s, d, t);
    #1;
    check("imemAddr", imemAddr, m_pc);
    check("ifInstr", ifInstr, m_instr);
    check("ifPc", ifPc, m_ifpc);
    check("ifValid", {31'd0, ifValid}, {31'd0, m_valid});
    check("halted", {31'd0, halted}, {31'd0, m_halt});
    check("fetchCount", fetchCount, m_cnt);
    check("fetchCountSat", fetchCount2, m_cnt2);
    check("imemAddrSat", imemAddr2, m_pc);
  endtask

  initial begin
    logic [31:0] w, tgt;
    for (int i = 0; i < 256; i++)
      mem[i] = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13;
    mem[4] = 32'h0000_0073;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_ifInstr", ifInstr, NOP);
    check("rst_count", fetchCount, 32'd0);

    // Sequential fetch, then stall at PC=8
    step(0, 0, 0, 0);
    check("seq_pc0", ifPc, 32'h0);
    step(0, 0, 0, 0);
    check("seq_pc4", ifPc, 32'h4);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("stall_ifPc", ifPc, 32'h4);
    check("stall_addr", imemAddr, 32'h8);
    step(0, 0, 0, 0);
    check("resume_pc8", ifPc, 32'h8);
    check("count3", fetchCount, 32'd3);

    // Ecall at 0x10
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("ecall_instr", ifInstr, 32'h73);
    check("ecall_pc", ifPc, 32'h10);
    check("ecall_halted", {31'd0, halted}, 32'd1);
    check("ecall_addr", imemAddr, 32'h14);
    repeat (3) step(0, 0, 0, 0);
    check("halt_valid", {31'd0, ifValid}, 32'd0);
    check("halt_count", fetchCount, 32'd5);
    check("sat_count", fetchCount2, 32'hFFFF_FFFF);

    // Escape halt with redirect to top of address space, then wrap
    step(0, 0, 1, 32'hFFFF_FFFC);
    check("esc_halted", {31'd0, halted}, 32'd0);
    step(0, 0, 0, 0);
    check("wrap_pc_top", ifPc, 32'hFFFF_FFFC);
    check("wrap_addr", imemAddr, 32'h0);
    step(0, 0, 0, 0);
    check("wrap_pc0", ifPc, 32'h0);
    check("sat_hold", fetchCount2, 32'hFFFF_FFFF);
    step(0, 0, 0, 0);

    // Redirect while stalled, unaligned target
    step(0, 1, 1, 32'h42);
    check("redir_addr", imemAddr, 32'h40);
    check("redir_instr", ifInstr, NOP);
    check("redir_valid", {31'd0, ifValid}, 32'd0);
    step(0, 0, 0, 0);
    check("redir_ifPc", ifPc, 32'h40);

    // Reset during a redirect
    step(1, 0, 1, 32'h80);
    check("mrst_addr", imemAddr, 32'h0);
    check("mrst_ifPc", ifPc, 32'h0);
    check("mrst_count", fetchCount, 32'd0);

    // Random traffic over a random program with sparse ecalls
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      mem[i] = ($urandom_range(19) == 0) ? {w[31:7], 7'h73} : {w[31:7], 7'h13};
    end
    for (int n = 0; n < 3000; n++) begin
      tgt = $urandom;
      tgt = ($urandom_range(3) == 0) ? {24'hFFFFFF, tgt[7:0]} : {22'd0, tgt[9:0]};
      step($urandom_range(199) == 0, $urandom_range(4) == 0,
           $urandom_range(9) == 0, tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
